wf_dac_player: RTL and testbench



---
 rtl/wf_dac_player.sv | 99 +++++++++
 tb/tb_wf_dac_player.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wf_dac_player.sv
// Plays packed 2x16-bit AXI-Stream words to the DAC, lo sample first, one sample per clock.
// Optional WF_PLAYER_OFFSET_BIN_EN: invert bit 15 of each waveform sample (two's complement -> offset binary).
module wf_dac_player #(
    parameter logic [15:0] IDLE_CODE = 16'h0000,
    parameter int          CNT_W     = 32
) (
    input  logic             clk_in1,
    input  logic             aresetn,
    input  logic             trigger,
    input  logic             abort,
    input  logic             clear_status,
    input  logic [31:0]      wf_axis_tdata,
    input  logic             wf_axis_tvalid,
    input  logic             wf_axis_tlast,
    output logic             wf_axis_tready,
    output logic [15:0]      dac_data,
    output logic             dac_valid,
    output logic             active,
    output logic             done,
    output logic             underrun,
    output logic [CNT_W-1:0] sample_count
);
    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_PLAY_LO, S_PLAY_HI, S_DONE} state_t;

    state_t      state;
    logic [15:0] hold_hi;
    logic        hold_last;
    logic        hs;

    function automatic logic [15:0] fmt(input logic [15:0] s);
`ifdef WF_PLAYER_OFFSET_BIN_EN
        return {~s[15], s[14:0]};
`else
        return s;
`endif
    endfunction

    // Ready is a pure state decode so the upstream never sees a tvalid->tready path.
    assign wf_axis_tready = (state == S_WAIT) || (state == S_PLAY_HI && !hold_last);
    assign hs             = wf_axis_tvalid && wf_axis_tready;
    assign active         = (state == S_WAIT) || (state == S_PLAY_LO) || (state == S_PLAY_HI);

    always_ff @(posedge clk_in1) begin
        if (!aresetn) begin
            state        <= S_IDLE;
            dac_data     <= IDLE_CODE;
            dac_valid    <= 1'b0;
            done         <= 1'b0;
            underrun     <= 1'b0;
            sample_count <= '0;
            hold_hi      <= 16'h0000;
            hold_last    <= 1'b0;
        end else begin
            if (dac_valid && sample_count != '1)
                sample_count <= sample_count + CNT_W'(1);
            if (clear_status)
                underrun <= 1'b0;
            done <= 1'b0;

            if (abort) begin
                state     <= S_IDLE;
                dac_valid <= 1'b0;
                dac_data  <= IDLE_CODE;
            end else if (hs) begin
                // Same load from WAIT and PLAY_HI keeps back-to-back words gapless.
                dac_data  <= fmt(wf_axis_tdata[15:0]);
                hold_hi   <= wf_axis_tdata[31:16];
                hold_last <= wf_axis_tlast;
                dac_valid <= 1'b1;
                state     <= S_PLAY_LO;
            end else begin
                case (state)
                    S_IDLE: if (trigger) begin
                        state        <= S_WAIT;
                        sample_count <= '0;
                    end
                    S_PLAY_LO: begin
                        dac_data <= fmt(hold_hi);
                        state    <= S_PLAY_HI;
                    end
                    S_PLAY_HI: begin
                        dac_data  <= IDLE_CODE;
                        dac_valid <= 1'b0;
                        if (hold_last) begin
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            // Stream ran dry mid-waveform; set beats a same-cycle clear.
                            underrun <= 1'b1;
                            state    <= S_WAIT;
                        end
                    end
                    S_DONE:  state <= S_IDLE;
                    default: state <= state;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_wf_dac_player.sv
// Self-checking bench for wf_dac_player: directed vector table, corner sequences, random streams vs a slot model.
module tb_wf_dac_player;
    localparam logic [15:0] IDLE_CODE = 16'h0000;
    localparam logic [31:0] W1 = 32'h0002_0001, W2 = 32'h0004_0003,
                            W3 = 32'h0006_0005, W4 = 32'h0008_0007;

    logic        clk_in1 = 1'b0, aresetn = 1'b0;
    logic        trigger = 1'b0, abort = 1'b0, clear_status = 1'b0;
    logic [31:0] wf_axis_tdata = 32'h0;
    logic        wf_axis_tvalid = 1'b0, wf_axis_tlast = 1'b0;
    logic        wf_axis_tready, dac_valid, active, done, underrun;
    logic [15:0] dac_data;
    logic [31:0] sample_count;

    wf_dac_player dut (
        .clk_in1(clk_in1), .aresetn(aresetn), .trigger(trigger), .abort(abort),
        .clear_status(clear_status), .wf_axis_tdata(wf_axis_tdata),
        .wf_axis_tvalid(wf_axis_tvalid), .wf_axis_tlast(wf_axis_tlast),
        .wf_axis_tready(wf_axis_tready), .dac_data(dac_data), .dac_valid(dac_valid),
        .active(active), .done(done), .underrun(underrun), .sample_count(sample_count)
    );

    always #5 clk_in1 = ~clk_in1;

    int tests = 0, fails = 0;

    function automatic logic [15:0] cv(input logic [15:0] s);
`ifdef WF_PLAYER_OFFSET_BIN_EN
        return s ^ 16'h8000;
`else
        return s;
`endif
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask
    task automatic chk1(input string nm, input logic act, input logic exp);
        chk(nm, {31'b0, act}, {31'b0, exp});
    endtask
    task automatic chk16(input string nm, input logic [15:0] act, input logic [15:0] exp);
        chk(nm, {16'b0, act}, {16'b0, exp});
    endtask

    // Drive one cycle of inputs, then step past the next rising edge.
    task automatic cy(input int trg, input int abt, input int clr, input int vld,
                      input logic [31:0] d, input int last);
        trigger        = (trg != 0);
        abort          = (abt != 0);
        clear_status   = (clr != 0);
        wf_axis_tvalid = (vld != 0);
        wf_axis_tdata  = d;
        wf_axis_tlast  = (last != 0);
        @(posedge clk_in1); #1;
    endtask

    typedef struct {
        logic        trg, abt, clr, vld, last;
        logic [31:0] tdata;
        logic [15:0] e_data;
        logic        e_vld, e_rdy, e_done, e_act, e_urun;
        int          e_cnt;
    } vec_t;
    vec_t tbl[$];

    function automatic vec_t v(input int trg, input int abt, input int clr, input int vld,
                               input logic [31:0] d, input int last, input int ed, input int ev,
                               input int er, input int edn, input int eact, input int eu, input int ecnt);
        vec_t r;
        r.trg = (trg != 0); r.abt = (abt != 0); r.clr = (clr != 0); r.vld = (vld != 0);
        r.tdata = d; r.last = (last != 0);
        r.e_vld  = (ev != 0);
        r.e_data = r.e_vld ? cv(16'(ed)) : IDLE_CODE;
        r.e_rdy = (er != 0); r.e_done = (edn != 0); r.e_act = (eact != 0); r.e_urun = (eu != 0);
        r.e_cnt = ecnt;
        return r;
    endfunction

    task automatic reset_chk(input string p);
        chk16({p, "_data"}, dac_data, IDLE_CODE);
        chk1({p, "_vld"}, dac_valid, 1'b0);
        chk1({p, "_done"}, done, 1'b0);
        chk1({p, "_urun"}, underrun, 1'b0);
        chk({p, "_cnt"}, sample_count, 32'd0);
        chk1({p, "_rdy"}, wf_axis_tready, 1'b0);
        chk1({p, "_act"}, active, 1'b0);
    endtask

    // Random-run model state: expected sample per post-edge cycle slot.
    logic [31:0] words[$];
    int          hs_t[$];
    logic [15:0] exp_d[int];
    int          n, cyc, idx, done_at, np;
    bit          tv, hs, fin, exp_u;

    initial begin
        // Full 4-word waveform with tvalid held high.
        tbl.push_back(v(1,0,0,0,0 ,0, 0,0,1,0,1,0,0));
        tbl.push_back(v(0,0,0,1,W1,0, 1,1,0,0,1,0,0));
        tbl.push_back(v(0,0,0,1,W2,0, 2,1,1,0,1,0,1));
        tbl.push_back(v(0,0,0,1,W2,0, 3,1,0,0,1,0,2));
        tbl.push_back(v(0,0,0,1,W3,0, 4,1,1,0,1,0,3));
        tbl.push_back(v(0,0,0,1,W3,0, 5,1,0,0,1,0,4));
        tbl.push_back(v(0,0,0,1,W4,1, 6,1,1,0,1,0,5));
        tbl.push_back(v(0,0,0,1,W4,1, 7,1,0,0,1,0,6));
        tbl.push_back(v(0,0,0,0,0 ,0, 8,1,0,0,1,0,7));
        tbl.push_back(v(0,0,0,0,0 ,0, 0,0,0,1,0,0,8));
        tbl.push_back(v(0,0,0,0,0 ,0, 0,0,0,0,0,0,8));
        // Same stream with a 3-cycle gap before word 3, then clear_status.
        tbl.push_back(v(1,0,0,0,0 ,0, 0,0,1,0,1,0,0));
        tbl.push_back(v(0,0,0,1,W1,0, 1,1,0,0,1,0,0));
        tbl.push_back(v(0,0,0,1,W2,0, 2,1,1,0,1,0,1));
        tbl.push_back(v(0,0,0,1,W2,0, 3,1,0,0,1,0,2));
        tbl.push_back(v(0,0,0,0,0 ,0, 4,1,1,0,1,0,3));
        tbl.push_back(v(0,0,0,0,0 ,0, 0,0,1,0,1,1,4));
        tbl.push_back(v(0,0,0,0,0 ,0, 0,0,1,0,1,1,4));
        tbl.push_back(v(0,0,0,1,W3,0, 5,1,0,0,1,1,4));
        tbl.push_back(v(0,0,0,1,W4,1, 6,1,1,0,1,1,5));
        tbl.push_back(v(0,0,0,1,W4,1, 7,1,0,0,1,1,6));
        tbl.push_back(v(0,0,0,0,0 ,0, 8,1,0,0,1,1,7));
        tbl.push_back(v(0,0,0,0,0 ,0, 0,0,0,1,0,1,8));
        tbl.push_back(v(0,0,1,0,0 ,0, 0,0,0,0,0,0,8));

        repeat (3) @(posedge clk_in1);
        #1;
        reset_chk("rst");
        aresetn = 1'b1;

        foreach (tbl[i]) begin
            cy(tbl[i].trg, tbl[i].abt, tbl[i].clr, tbl[i].vld, tbl[i].tdata, tbl[i].last);
            chk16($sformatf("tbl%0d_data", i), dac_data, tbl[i].e_data);
            chk1($sformatf("tbl%0d_vld", i), dac_valid, tbl[i].e_vld);
            chk1($sformatf("tbl%0d_rdy", i), wf_axis_tready, tbl[i].e_rdy);
            chk1($sformatf("tbl%0d_done", i), done, tbl[i].e_done);
            chk1($sformatf("tbl%0d_act", i), active, tbl[i].e_act);
            chk1($sformatf("tbl%0d_urun", i), underrun, tbl[i].e_urun);
            chk($sformatf("tbl%0d_cnt", i), sample_count, 32'(tbl[i].e_cnt));
        end

        // Abort while sample 3 is on the output; handshake offered at the same time.
        cy(1,0,0,0,0,0); cy(0,0,0,1,W1,0); cy(0,0,0,1,W2,0); cy(0,0,0,1,W2,0);
        chk16("ab_pre", dac_data, cv(16'd3));
        cy(0,1,0,1,W3,0);
        chk1("ab_vld", dac_valid, 1'b0); chk16("ab_data", dac_data, IDLE_CODE);
        chk1("ab_rdy", wf_axis_tready, 1'b0); chk1("ab_act", active, 1'b0);
        chk("ab_cnt", sample_count, 32'd3);
        cy(0,0,0,1,W3,0);
        chk1("ab_done", done, 1'b0); chk1("ab_rdy2", wf_axis_tready, 1'b0);
        cy(1,0,0,0,0,0);
        chk("ab_restart_cnt", sample_count, 32'd0); chk1("ab_restart_rdy", wf_axis_tready, 1'b1);
        cy(0,1,0,0,0,0);

        // Offset-binary word, trigger in PLAY_HI and in DONE ignored.
        np = 0;
        cy(1,0,0,0,0,0);
        cy(0,0,0,1,32'h7FFF_8000,0); np += int'(done);
        chk16("ob_lo", dac_data, cv(16'h8000));
        cy(0,0,0,1,W2,1); np += int'(done);
        chk16("ob_hi", dac_data, cv(16'h7FFF));
        cy(1,0,0,1,W2,1); np += int'(done);
        chk16("trg_hi_data", dac_data, cv(16'd3)); chk1("trg_hi_act", active, 1'b1);
        cy(0,0,0,0,0,0); np += int'(done);
        chk16("trg_d4", dac_data, cv(16'd4)); chk1("trg_rdy_last", wf_axis_tready, 1'b0);
        cy(0,0,0,0,0,0); np += int'(done);
        chk1("trg_done", done, 1'b1); chk16("ob_idle", dac_data, IDLE_CODE);
        cy(1,0,0,0,0,0); np += int'(done);
        chk1("trg_dn_act", active, 1'b0); chk1("trg_dn_rdy", wf_axis_tready, 1'b0);
        cy(0,0,0,0,0,0); np += int'(done);
        chk1("trg_dn_idle_rdy", wf_axis_tready, 1'b0); chk1("trg_dn_idle_act", active, 1'b0);
        chk("trg_done_pulses", 32'(np), 32'd1);

        // trigger and abort together in IDLE.
        cy(1,1,0,0,0,0);
        chk1("ta_rdy", wf_axis_tready, 1'b0); chk1("ta_act", active, 1'b0);
        cy(0,0,0,0,0,0);
        chk1("ta_rdy2", wf_axis_tready, 1'b0);

        // Underrun set and clear_status in the same cycle: set wins.
        cy(1,0,0,0,0,0); cy(0,0,0,1,W1,0); cy(0,0,0,0,0,0);
        cy(0,0,1,0,0,0);
        chk1("uc_set_wins", underrun, 1'b1);
        cy(0,0,1,0,0,0);
        chk1("uc_cleared", underrun, 1'b0);
        cy(0,1,0,0,0,0);

        // Reset mid-playback.
        cy(1,0,0,0,0,0); cy(0,0,0,1,W1,0);
        aresetn = 1'b0;
        cy(0,0,0,0,0,0);
        reset_chk("mrst");
        aresetn = 1'b1;
        cy(0,0,0,0,0,0);

        // Random waveforms: every accepted word owns the two slots after its handshake edge.
        for (int w = 0; w < 25; w++) begin
            n = $urandom_range(1, 6);
            words.delete(); hs_t.delete(); exp_d.delete();
            for (int k = 0; k < n; k++) words.push_back($urandom);
            cy(0,0,1,0,0,0);
            cy(1,0,0,0,0,0);
            trigger = 1'b0;
            cyc = 0; idx = 0; done_at = -1; fin = 0; tv = 0;
            while (!fin && cyc < 200) begin
                if (!tv && idx < n) tv = ($urandom_range(0, 3) != 0);
                wf_axis_tvalid = tv;
                wf_axis_tdata  = (idx < n) ? words[idx] : 32'h0;
                wf_axis_tlast  = (idx == n - 1);
                hs = tv && wf_axis_tready;
                @(posedge clk_in1); #1;
                cyc++;
                if (hs) begin
                    exp_d[cyc]     = words[idx][15:0];
                    exp_d[cyc + 1] = words[idx][31:16];
                    hs_t.push_back(cyc);
                    if (idx == n - 1) done_at = cyc + 2;
                    idx++;
                    tv = 0;
                end
                if (exp_d.exists(cyc)) begin
                    chk1($sformatf("rnd%0d_c%0d_vld", w, cyc), dac_valid, 1'b1);
                    chk16($sformatf("rnd%0d_c%0d_data", w, cyc), dac_data, cv(exp_d[cyc]));
                end else begin
                    chk1($sformatf("rnd%0d_c%0d_vld", w, cyc), dac_valid, 1'b0);
                    chk16($sformatf("rnd%0d_c%0d_data", w, cyc), dac_data, IDLE_CODE);
                end
                chk1($sformatf("rnd%0d_c%0d_done", w, cyc), done, cyc == done_at);
                if (cyc == done_at) fin = 1;
            end
            chk1($sformatf("rnd%0d_finished", w), fin, 1'b1);
            exp_u = 0;
            for (int k = 0; k + 1 < hs_t.size(); k++)
                if (hs_t[k + 1] != hs_t[k] + 2) exp_u = 1;
            chk1($sformatf("rnd%0d_urun", w), underrun, exp_u);
            chk($sformatf("rnd%0d_cnt", w), sample_count, 32'(2 * n));
            cy(0,0,0,0,0,0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, tests=%0d", tests);
        $fatal(1);
    end
endmodule
